// File: rtl/wdt_kicker.sv
// Watchdog servicer: keeps a cycle-count watchdog alive with periodic one-cycle kicks while heartbeats arrive.
// Optional kick statistics counter (kick_cnt_o) is enabled by defining WDT_KICKER_STATS_EN.
module wdt_kicker #(
    parameter int KICK_PERIOD = 64,
    parameter int MAX_MISS    = 3,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       alive,
    input  logic       wdt_bite,
    output logic       wd_en_o,
    output logic       kick_o,
    output logic       fault_o,
    output logic       bite_o,
    output logic [3:0] miss_o
`ifdef WDT_KICKER_STATS_EN
    ,
    output logic [15:0] kick_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        KICK  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(KICK_PERIOD - 1);
    localparam logic [3:0]       MISS_LIMIT = 4'(MAX_MISS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             alive_seen;
    logic [3:0]       miss_inc;
    logic             kick_now;

    assign miss_inc = miss_o + 4'd1;

    // A kick is granted at the last cycle of a period if a heartbeat was seen anywhere in it,
    // including that very cycle; enable-drop and bite both pre-empt the decision.
    assign kick_now = en && !wdt_bite && (state == RUN) && (cnt == LAST_CNT) && (alive_seen || alive);

    // Outputs are registered alongside the state so they reflect the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            alive_seen <= 1'b0;
            miss_o     <= 4'd0;
            wd_en_o    <= 1'b0;
            kick_o     <= 1'b0;
            fault_o    <= 1'b0;
            bite_o     <= 1'b0;
        end else begin
            kick_o <= 1'b0;
            if (wdt_bite && state != IDLE) begin
                bite_o <= 1'b1;
            end

            if (!en) begin
                state      <= IDLE;
                cnt        <= '0;
                alive_seen <= 1'b0;
                miss_o     <= 4'd0;
                wd_en_o    <= 1'b0;
                fault_o    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= RUN;
                        cnt        <= '0;
                        alive_seen <= 1'b0;
                        miss_o     <= 4'd0;
                        wd_en_o    <= 1'b1;
                    end
                    RUN, KICK: begin
                        if (wdt_bite) begin
                            state   <= FAULT;
                            wd_en_o <= 1'b1;
                            fault_o <= 1'b1;
                        end else if (state == KICK) begin
                            // A heartbeat during the kick cycle counts toward the new period.
                            state      <= RUN;
                            cnt        <= '0;
                            alive_seen <= alive;
                            wd_en_o    <= 1'b1;
                        end else if (cnt == LAST_CNT) begin
                            cnt        <= '0;
                            alive_seen <= 1'b0;
                            if (kick_now) begin
                                state   <= KICK;
                                miss_o  <= 4'd0;
                                wd_en_o <= 1'b0;
                                kick_o  <= 1'b1;
                            end else if (miss_inc >= MISS_LIMIT) begin
                                state   <= FAULT;
                                miss_o  <= MISS_LIMIT;
                                wd_en_o <= 1'b1;
                                fault_o <= 1'b1;
                            end else begin
                                miss_o <= miss_inc;
                            end
                        end else begin
                            cnt        <= cnt + 1'b1;
                            alive_seen <= alive_seen | alive;
                        end
                    end
                    FAULT: begin
                        wd_en_o <= 1'b1;
                        fault_o <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        wd_en_o <= 1'b0;
                        fault_o <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef WDT_KICKER_STATS_EN
    // Lifetime kick count; survives service disable and saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kick_cnt_o <= 16'd0;
        end else if (kick_now && kick_cnt_o != 16'hFFFF) begin
            kick_cnt_o <= kick_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wdt_kicker.sv
// Randomized scoreboard bench for wdt_kicker (KICK_PERIOD=8, MAX_MISS=2) against a period-level reference model.
module tb_wdt_kicker;

    localparam int KP = 8;
    localparam int MM = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_KICK  = 2;
    localparam int M_FAULT = 3;

    logic        clk;
    logic        rst;
    logic        en;
    logic        alive;
    logic        wdt_bite;
    logic        wd_en_o;
    logic        kick_o;
    logic        fault_o;
    logic        bite_o;
    logic [3:0]  miss_o;
`ifdef WDT_KICKER_STATS_EN
    logic [15:0] kick_cnt_o;
`endif

    typedef struct {
        logic       wd_en;
        logic       kick;
        logic       fault;
        logic       bite;
        logic [3:0] miss;
        int         kicks;
    } exp_t;

    exp_t exp_q[$];
    exp_t rst_q[$];

    int vectors;
    int miscompares;
    int cycle;

    int m_mode;
    int m_cnt;
    int m_heard;
    int m_miss;
    int m_bite;
    int m_kicks;

    wdt_kicker #(
        .KICK_PERIOD(KP),
        .MAX_MISS   (MM),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .alive     (alive),
        .wdt_bite  (wdt_bite),
        .wd_en_o   (wd_en_o),
        .kick_o    (kick_o),
        .fault_o   (fault_o),
        .bite_o    (bite_o),
        .miss_o    (miss_o)
`ifdef WDT_KICKER_STATS_EN
        ,
        .kick_cnt_o(kick_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_outputs();
        exp_t e;
        e.wd_en = (m_mode == M_RUN || m_mode == M_FAULT);
        e.kick  = (m_mode == M_KICK);
        e.fault = (m_mode == M_FAULT);
        e.bite  = (m_bite != 0);
        e.miss  = 4'(m_miss);
        e.kicks = m_kicks;
        return e;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_cnt   = 0;
        m_heard = 0;
        m_miss  = 0;
        m_bite  = 0;
        m_kicks = 0;
    endtask

    // Period-level reference: a period is KP run cycles; at its end either a kick is owed or a miss is recorded.
    task automatic model_step(input logic e, input logic a, input logic b);
        if (!e) begin
            if (b && m_mode != M_IDLE) m_bite = 1;
            m_mode = M_IDLE;
            m_miss = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode  = M_RUN;
            m_cnt   = 0;
            m_heard = 0;
            m_miss  = 0;
        end else if (b) begin
            m_bite = 1;
            m_mode = M_FAULT;
        end else if (m_mode == M_KICK) begin
            m_mode  = M_RUN;
            m_cnt   = 0;
            m_heard = a ? 1 : 0;
        end else if (m_mode == M_RUN) begin
            if (a) m_heard = 1;
            if (m_cnt == KP - 1) begin
                m_cnt = 0;
                if (m_heard != 0) begin
                    m_mode  = M_KICK;
                    m_miss  = 0;
                    m_kicks = (m_kicks < 65535) ? m_kicks + 1 : 65535;
                end else begin
                    m_miss = (m_miss + 1 > MM) ? MM : m_miss + 1;
                    if (m_miss == MM) m_mode = M_FAULT;
                end
                m_heard = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic a, input logic b);
        @(negedge clk);
        rst      = r;
        en       = e;
        alive    = a;
        wdt_bite = b;
        if (r) model_reset();
        else model_step(e, a, b);
        exp_q.push_back(model_outputs());
    endtask

    task automatic pulse_async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        rst_q.push_back(model_outputs());
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_output(input string name, input exp_t e);
        logic ok;
        ok = (wd_en_o === e.wd_en) && (kick_o === e.kick) && (fault_o === e.fault) &&
             (bite_o === e.bite) && (miss_o === e.miss);
`ifdef WDT_KICKER_STATS_EN
        ok = ok && (kick_cnt_o === 16'(e.kicks));
`endif
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got wd_en=%b kick=%b fault=%b bite=%b miss=%0d, expected wd_en=%b kick=%b fault=%b bite=%b miss=%0d kicks=%0d",
                     name, cycle, wd_en_o, kick_o, fault_o, bite_o, miss_o,
                     e.wd_en, e.kick, e.fault, e.bite, e.miss, e.kicks);
        end
    endtask

    // Monitor: every clock edge the DUT presents a new registered output word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) check_output("outputs", exp_q.pop_front());
        end
    end

    // Reset must clear outputs immediately, before any clock edge.
    initial begin
        forever begin
            @(posedge rst);
            #1;
            if (rst_q.size() > 0) check_output("async_reset", rst_q.pop_front());
        end
    end

    initial begin
        logic a;
        vectors     = 0;
        miscompares = 0;
        cycle       = 0;
        rst         = 1'b1;
        en          = 1'b0;
        alive       = 1'b0;
        wdt_bite    = 1'b0;
        model_reset();

        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

        // Disabled: heartbeats and bites are both irrelevant.
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Mostly healthy heartbeat traffic.
        for (int i = 0; i < 150; i++)
            apply_stimulus(1'b0, 1'b1, 1'($urandom_range(0, 3) == 0), 1'b0);

        pulse_async_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Silent monitored logic: two misses then fault.
        for (int i = 0; i < 25; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Heartbeat only on the decision cycle, and only after one miss; then only during kicks.
        for (int i = 0; i < 80; i++) begin
            a = (m_mode == M_KICK) || (m_mode == M_RUN && m_cnt == KP - 1 && m_miss == 1);
            apply_stimulus(1'b0, 1'b1, a, 1'b0);
        end

        // Bite coinciding with disable while running.
        while (m_mode != M_RUN) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Bite while running forces fault.
        for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Unconstrained mix.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) pulse_async_reset();
            apply_stimulus(1'b0, 1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 4) == 0),
                           1'($urandom_range(0, 299) == 0));
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0 || rst_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", exp_q.size() + rst_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wdt_kicker.md
Name: wdt_kicker

Overview:
- Watchdog servicing block: drives the enable of a cycle-count watchdog and periodically "kicks" it.
- A kick is a one-cycle deassertion of the watchdog enable, which clears the watchdog's counter.
- A kick is issued only while the monitored logic proves liveness via alive pulses. On repeated missed heartbeats the block stops kicking so the watchdog fires.
- Sits beside the watchdog timer and also observes its reset output (bite).

Parameters:
- KICK_PERIOD, 64, RUN cycles between kick decisions; must be less than the watchdog timeout (100 cycles); legal range 2..127.
- MAX_MISS, 3, consecutive periods without an alive pulse before FAULT; legal range 1..15.
- CNT_W, 7, width of the period counter; must satisfy 2^CNT_W > KICK_PERIOD.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  service enable; 0 forces IDLE
- alive  input  1  heartbeat pulse from monitored logic; any-length high counts once per period
- wdt_bite  input  1  watchdog reset output (rst_o of the watchdog)
- wd_en_o  output  1  enable to the watchdog; low = counter cleared
- kick_o  output  1  one-cycle pulse, coincident with the kick cycle
- fault_o  output  1  high in FAULT state
- bite_o  output  1  sticky; watchdog has fired while serviced
- miss_o  output  4  current consecutive-miss count

Behaviour:
- Reset (async): state=IDLE, cnt=0, miss=0, alive_seen=0. Outputs wd_en_o=0, kick_o=0, fault_o=0, bite_o=0, miss_o=0.
- All outputs are registered, driven from next-state. One-cycle latency from input sample to output.
- IDLE: wd_en_o=0. If en=1 at an edge, go to RUN; cnt=0, alive_seen=0, miss=0.
- RUN: wd_en_o=1; cnt increments each cycle. alive=1 sets alive_seen. Decision occurs at cnt==KICK_PERIOD-1:
  - If alive_seen=1 or alive=1 this cycle: go to KICK; miss=0.
  - Otherwise: miss=miss+1, cnt=0, alive_seen=0. If the new miss equals MAX_MISS, go to FAULT; else stay in RUN.
- KICK: exactly one cycle with wd_en_o=0 and kick_o=1. cnt=0, alive_seen cleared, then RUN. An alive pulse during KICK is recorded for the next period.
- FAULT: wd_en_o=1, fault_o=1, no kicks, cnt frozen, miss holds MAX_MISS. Exits only via en=0 or rst.
- en=0 in any state: IDLE at next edge, wd_en_o=0, fault_o=0, miss=0. bite_o is unaffected.
- wdt_bite=1 in RUN, KICK or FAULT: bite_o set (sticky until rst) and state goes to FAULT. wdt_bite in IDLE is ignored.
- Simultaneous events, by priority: en=0 > wdt_bite > decision logic.
- miss saturates at MAX_MISS; no wrap.
- Period counter never exceeds KICK_PERIOD-1. Consequently, with no misses, the watchdog enable is never high for more than KICK_PERIOD consecutive cycles.

Optional Feature:
- Macro: WDT_KICKER_STATS_EN.
- Defined: adds output kick_cnt_o [15:0], counting kicks issued.
  - Reset to 0 by rst; not cleared by en=0.
  - Saturates at 16'hFFFF.
  - Increments on each kick_o cycle.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan (KICK_PERIOD=8, MAX_MISS=2 unless noted):
- Reset and idle: rst pulsed mid-RUN → all outputs 0 immediately (async). en=0 for 20 cycles → wd_en_o stays 0, kick_o never high.
- Healthy kicking: en=1, alive pulsed once per 8 cycles → wd_en_o rises 1 cycle after en. kick_o pulses every 9 cycles (8 RUN + 1 KICK), with wd_en_o=0 in each kick cycle. miss_o=0 throughout. Against the real watchdog (timeout 100), rst_o never asserts over 1000 cycles.
- Missed heartbeats: alive held 0 → miss_o=1 after the first decision and 2 after the second. fault_o=1 and no kick_o after 16 RUN cycles. Against the real watchdog, rst_o asserts ~100 cycles later, then bite_o=1.
- Recovery: one miss followed by alive in the next period → miss_o returns 0 and a kick occurs. Then en=0 in FAULT → IDLE next cycle, fault_o=0, miss_o=0, bite_o still set if previously set.
- Edge cases:
  - alive arriving exactly at the decision cycle (cnt=7) → kick, not a miss.
  - alive during the KICK cycle → credited to the next period.
  - wdt_bite and en=0 in the same cycle → IDLE, with bite_o=1.
- STATS build: 5 kicks → kick_cnt_o=5. en toggled off and on → still 5. rst → 0.
